// File: rtl/meteor_renderer_pkg.sv
// Shared definitions for the meteor renderer: screen bounds, field widths
// and the frame-sequencer state encoding.
package meteor_renderer_pkg;

    localparam int SCR_W = 320;   // visible screen width in pixels
    localparam int SCR_H = 240;   // visible screen height in pixels
    localparam int COL_W = 3;     // colour width
    localparam int X_W   = 10;    // x coordinate width
    localparam int Y_W   = 9;     // y coordinate width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/meteor_renderer_box_scan.sv
// box_scan: row-major sweep over a SIZE x SIZE box.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_clear         force the sweep back to (0,0) on the next edge
//   i_step          advance one pixel (wraps to (0,0) after the last one)
//   o_cx, o_cy      current pixel offset inside the box
//   o_cx_nxt/o_cy_nxt  offset the sweep will hold after the next edge
//   o_last          current offset is the final pixel (SIZE-1, SIZE-1)
module box_scan
    import meteor_renderer_pkg::*;
#(
    parameter int SIZE = 10
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_clear,
    input  logic           i_step,
    output logic [X_W-1:0] o_cx,
    output logic [Y_W-1:0] o_cy,
    output logic [X_W-1:0] o_cx_nxt,
    output logic [Y_W-1:0] o_cy_nxt,
    output logic           o_last
);

    logic [X_W-1:0] r_cx;
    logic [Y_W-1:0] r_cy;
    logic           w_cx_end;
    logic           w_cy_end;

    assign w_cx_end = (r_cx == X_W'(SIZE - 1));
    assign w_cy_end = (r_cy == Y_W'(SIZE - 1));

    // NOTE: every output of a combinational block gets a default first so no
    // path through the branches leaves a value unassigned (which infers a latch).
    always_comb begin
        o_cx_nxt = r_cx;
        o_cy_nxt = r_cy;
        if (i_clear) begin
            o_cx_nxt = '0;
            o_cy_nxt = '0;
        end else if (i_step) begin
            if (w_cx_end) begin
                o_cx_nxt = '0;
                o_cy_nxt = w_cy_end ? '0 : r_cy + 1'b1;
            end else begin
                o_cx_nxt = r_cx + 1'b1;
            end
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cx <= '0;
            r_cy <= '0;
        end else begin
            r_cx <= o_cx_nxt;
            r_cy <= o_cy_nxt;
        end
    end

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_last = w_cx_end && w_cy_end;

endmodule

// File: rtl/meteor_renderer.sv
// meteor_renderer: per frame, erases the previous meteor box (if one was
// drawn) and draws the new one, one pixel per clock, with screen clipping.
// Ports:
//   i_clk, m_reset            clock, asynchronous active-low reset
//   m_frame                   one-cycle frame start (accepted only in IDLE)
//   restart                   synchronous abort back to IDLE
//   enable, m_x, m_y, colour  meteor visibility, top-left corner, colour
//   vga_x, vga_y, vga_colour  registered pixel write address / data
//   plot                      pixel write strobe
//   busy, done                frame in progress, one-cycle completion pulse
module meteor_renderer
    import meteor_renderer_pkg::*;
#(
    parameter int              SIZE      = 10,
    parameter logic [COL_W-1:0] BG_COLOUR = 3'b000,
    parameter int              SCR_W     = meteor_renderer_pkg::SCR_W,
    parameter int              SCR_H     = meteor_renderer_pkg::SCR_H
) (
    input  logic             i_clk,
    input  logic             m_reset,
    input  logic             m_frame,
    input  logic             restart,
    input  logic             enable,
    input  logic [X_W-1:0]   m_x,
    input  logic [Y_W-1:0]   m_y,
    input  logic [COL_W-1:0] colour,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_colour,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    state_t           r_state, w_state_nxt;
    logic             r_have_prev;
    logic [X_W-1:0]   r_prev_x, r_new_x;
    logic [Y_W-1:0]   r_prev_y, r_new_y;
    logic [COL_W-1:0] r_new_col;
    logic             r_new_en;
    logic [X_W-1:0]   r_vga_x;
    logic [Y_W-1:0]   r_vga_y;
    logic [COL_W-1:0] r_vga_col;
    logic             r_plot;

    logic [X_W-1:0]   w_cx, w_cx_nxt;
    logic [Y_W-1:0]   w_cy, w_cy_nxt;
    logic             w_last;
    logic             w_scanning;
    logic             w_accept;
    logic             w_emit;
    logic [X_W-1:0]   w_base_x;
    logic [Y_W-1:0]   w_base_y;
    logic [COL_W-1:0] w_col;
    logic [X_W:0]     w_sum_x;
    logic [Y_W:0]     w_sum_y;
    logic             w_on_screen;

    assign w_scanning = (r_state == ST_ERASE) || (r_state == ST_DRAW);
    assign w_accept   = (r_state == ST_IDLE) && m_frame && !restart;

    // The sweep is held at (0,0) outside ERASE/DRAW; wrapping after the last
    // erase pixel lands on (0,0) for the draw pass.
    box_scan #(.SIZE(SIZE)) u_scan (
        .i_clk    (i_clk),
        .i_rst_n  (m_reset),
        .i_clear  (restart || !w_scanning),
        .i_step   (w_scanning),
        .o_cx     (w_cx),
        .o_cy     (w_cy),
        .o_cx_nxt (w_cx_nxt),
        .o_cy_nxt (w_cy_nxt),
        .o_last   (w_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (restart) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (m_frame) w_state_nxt = r_have_prev ? ST_ERASE :
                                                     (enable ? ST_DRAW : ST_FIN);
                ST_ERASE: if (w_last) w_state_nxt = r_new_en ? ST_DRAW : ST_FIN;
                ST_DRAW:  if (w_last) w_state_nxt = ST_FIN;
                ST_FIN:   w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Pixel outputs are registered, so they are computed from the state and
    // sweep offset that will be current after this edge. On the accept edge
    // the new_* registers are still loading, hence the bypass from the inputs.
    always_comb begin
        w_emit   = (w_state_nxt == ST_ERASE) || (w_state_nxt == ST_DRAW);
        w_base_x = r_new_x;
        w_base_y = r_new_y;
        w_col    = r_new_col;
        if (w_state_nxt == ST_ERASE) begin
            w_base_x = r_prev_x;
            w_base_y = r_prev_y;
            w_col    = BG_COLOUR;
        end else if (r_state == ST_IDLE) begin
            w_base_x = m_x;
            w_base_y = m_y;
            w_col    = colour;
        end
        // One extra bit so a sum past the coordinate range still clips.
        w_sum_x     = {1'b0, w_base_x} + {1'b0, w_cx_nxt};
        w_sum_y     = {1'b0, w_base_y} + {1'b0, w_cy_nxt};
        w_on_screen = (w_sum_x < (X_W + 1)'(SCR_W)) && (w_sum_y < (Y_W + 1)'(SCR_H));
    end

    always_ff @(posedge i_clk or negedge m_reset) begin
        if (!m_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge m_reset) begin
        if (!m_reset) begin
            r_have_prev <= 1'b0;
            r_prev_x    <= '0;
            r_prev_y    <= '0;
            r_new_x     <= '0;
            r_new_y     <= '0;
            r_new_col   <= '0;
            r_new_en    <= 1'b0;
            r_vga_x     <= '0;
            r_vga_y     <= '0;
            r_vga_col   <= '0;
            r_plot      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_new_x   <= m_x;
                r_new_y   <= m_y;
                r_new_col <= colour;
                r_new_en  <= enable;
            end
            if (restart) begin
                r_have_prev <= 1'b0;
            end else if (r_state == ST_FIN) begin
                r_prev_x    <= r_new_x;
                r_prev_y    <= r_new_y;
                r_have_prev <= r_new_en;
            end
            r_plot <= w_emit && w_on_screen;
            if (w_emit) begin
                r_vga_x   <= w_sum_x[X_W-1:0];
                r_vga_y   <= w_sum_y[Y_W-1:0];
                r_vga_col <= w_col;
            end
        end
    end

    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_col;
    assign plot       = r_plot;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_FIN);

endmodule

// File: tb/tb_meteor_renderer.sv
// Directed bench for meteor_renderer: stimulus pushes the expected plotted
// pixels into a queue; a monitor pops one per plot strobe and compares.
module tb_meteor_renderer;

    localparam int SIZE = 10;
    localparam int TMO  = 400;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] c;
    } pix_t;

    logic       i_clk = 1'b0;
    logic       m_reset = 1'b0;
    logic       m_frame = 1'b0;
    logic       restart = 1'b0;
    logic       enable = 1'b0;
    logic [9:0] m_x = '0;
    logic [8:0] m_y = '0;
    logic [2:0] colour = '0;
    logic [9:0] vga_x;
    logic [8:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, busy, done;

    meteor_renderer dut (
        .i_clk      (i_clk),
        .m_reset    (m_reset),
        .m_frame    (m_frame),
        .restart    (restart),
        .enable     (enable),
        .m_x        (m_x),
        .m_y        (m_y),
        .colour     (colour),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 i_clk = ~i_clk;

    int   n_checks = 0;
    int   n_errors = 0;
    pix_t exp_q[$];
    int   plot_cnt = 0;
    int   done_cnt = 0;

    // Bench-side memory of the last drawn box.
    bit   mdl_have = 1'b0;
    int   mdl_x = 0;
    int   mdl_y = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected plotted pixels of one box pass, limited to the first `limit`
    // scan positions; off-screen pixels are scanned but never plotted.
    task automatic push_box(input int bx, input int by, input logic [2:0] c, input int limit);
        for (int k = 0; k < SIZE * SIZE; k++) begin
            int px, py;
            px = bx + k % SIZE;
            py = by + k / SIZE;
            if (k < limit && px < 320 && py < 240) exp_q.push_back('{px, py, c});
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge i_clk) begin
        #1;
        if (plot === 1'b1) begin
            plot_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_plot", plot, 0);
            end else begin
                pix_t e;
                e = exp_q.pop_front();
                check("pix_x", vga_x, e.x);
                check("pix_y", vga_y, e.y);
                check("pix_colour", vga_colour, e.c);
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic run_frame(input int x, input int y, input logic [2:0] c, input logic en,
                             input int exp_lat, input int exp_plots, input bit noise);
        int lat;
        if (mdl_have) push_box(mdl_x, mdl_y, 3'b000, SIZE * SIZE);
        if (en) push_box(x, y, c, SIZE * SIZE);
        plot_cnt = 0;
        done_cnt = 0;
        @(negedge i_clk);
        m_x = 10'(x); m_y = 9'(y); colour = c; enable = en; m_frame = 1'b1;
        @(negedge i_clk);
        m_frame = 1'b0;
        lat = 1;
        check("busy_after_accept", busy, 1);
        while (done !== 1'b1 && lat < TMO) begin
            if (noise) begin
                m_frame = (lat % 5 == 0) && (lat <= 20);
                m_x = 10'($urandom_range(0, 300));
                m_y = 9'($urandom_range(0, 200));
                colour = 3'($urandom);
                enable = 1'($urandom);
            end
            @(negedge i_clk);
            lat++;
        end
        m_frame = 1'b0;
        check("done_latency", lat, exp_lat);
        @(negedge i_clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("plot_count", plot_cnt, exp_plots);
        check("scoreboard_drained", exp_q.size(), 0);
        check("done_count", done_cnt, 1);
        exp_q.delete();
        mdl_x = x;
        mdl_y = y;
        mdl_have = en;
    endtask

    task automatic do_restart();
        @(negedge i_clk);
        restart = 1'b1;
        @(negedge i_clk);
        restart = 1'b0;
        mdl_have = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge i_clk);
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_y", vga_y, 0);
        check("rst_vga_colour", vga_colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        m_reset = 1'b1;

        // First frame: draw only; second: erase then draw.
        run_frame(100, 50, 3'b100, 1'b1, 101, 100, 1'b0);
        run_frame(101, 51, 3'b010, 1'b1, 201, 200, 1'b0);

        // Corner clipping with no previous box: 25 of 100 pixels visible.
        do_restart();
        run_frame(315, 235, 3'b111, 1'b1, 101, 25, 1'b0);
        // Erase of the clipped box (25) plus a full draw (100).
        run_frame(20, 30, 3'b001, 1'b1, 201, 125, 1'b0);
        // Hidden meteor: erase-only, then the next frame skips erase.
        run_frame(0, 0, 3'b011, 1'b0, 101, 100, 1'b0);
        // Extra m_frame pulses and input churn while busy are ignored.
        run_frame(40, 40, 3'b101, 1'b1, 101, 100, 1'b1);

        // Restart mid-DRAW: 30 pixels out, then IDLE with no done.
        do_restart();
        push_box(60, 60, 3'b110, 30);
        plot_cnt = 0;
        done_cnt = 0;
        @(negedge i_clk);
        m_x = 10'd60; m_y = 9'd60; colour = 3'b110; enable = 1'b1; m_frame = 1'b1;
        @(negedge i_clk);
        m_frame = 1'b0;
        repeat (29) @(negedge i_clk);
        restart = 1'b1;
        @(negedge i_clk);
        restart = 1'b0;
        check("restart_busy", busy, 0);
        check("restart_plot", plot, 0);
        repeat (150) @(negedge i_clk);
        check("restart_no_done", done_cnt, 0);
        check("restart_plot_count", plot_cnt, 30);
        check("restart_drained", exp_q.size(), 0);
        // restart together with m_frame in IDLE: frame not accepted.
        restart = 1'b1; m_frame = 1'b1;
        @(negedge i_clk);
        restart = 1'b0; m_frame = 1'b0;
        check("restart_wins_busy", busy, 0);
        repeat (3) @(negedge i_clk);
        check("restart_wins_idle", busy, 0);
        mdl_have = 1'b0;

        // Reset mid-ERASE: 20 erase pixels out, then everything clears.
        run_frame(200, 100, 3'b010, 1'b1, 101, 100, 1'b0);
        push_box(200, 100, 3'b000, 20);
        plot_cnt = 0;
        done_cnt = 0;
        @(negedge i_clk);
        m_x = 10'd210; m_y = 9'd110; colour = 3'b011; enable = 1'b1; m_frame = 1'b1;
        @(negedge i_clk);
        m_frame = 1'b0;
        repeat (19) @(negedge i_clk);
        m_reset = 1'b0;
        #1;
        check("arst_vga_x", vga_x, 0);
        check("arst_vga_y", vga_y, 0);
        check("arst_vga_colour", vga_colour, 0);
        check("arst_plot", plot, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        repeat (250) @(negedge i_clk);
        check("arst_no_done", done_cnt, 0);
        check("arst_plot_count", plot_cnt, 20);
        check("arst_drained", exp_q.size(), 0);
        m_reset = 1'b1;
        mdl_have = 1'b0;

        // Neither pass: invisible meteor with nothing to erase.
        run_frame(5, 5, 3'b001, 1'b0, 1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
